// File: rtl/traffic_light_monitor.sv
//-----------------------------------------------------------------------------
// traffic_light_monitor
//
// Passive safety checker for the four-way intersection light buses. Every
// clock it samples the north/south/east/west light codes, compares them with
// the previously sampled codes and per-direction dwell counters, and latches
// the first safety violation into a sticky fault. The fault output drives the
// lamp-board failsafe (all-red flash).
//
// Light encoding: 2'b00 red, 2'b01 green, 2'b10 yellow, 2'b11 illegal.
// Direction index: 0=N, 1=S, 2=E, 3=W.
//
// Violation codes (lowest code wins, then lowest direction index):
//   1 illegal code, 2 conflicting non-red directions, 3 illegal transition,
//   4 short green, 5 short yellow, 6 out-of-order green entry.
//
// Optional feature macro: ORDER_CHECK_EN
//   When defined, green entries must follow the rotation N->E->S->W->N.
//   When undefined, no order logic is built and code 6 never appears.
//
// Parameters:
//   MIN_GREEN  minimum consecutive sampled cycles a direction stays green
//   MIN_YELLOW minimum consecutive sampled cycles a direction stays yellow
//   CNT_W      width of the saturating per-direction dwell counters
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   n_lights   north light code
//   s_lights   south light code
//   e_lights   east light code
//   w_lights   west light code
//   clr_fault  synchronous clear of sticky fault state (rst has priority)
//   fault      sticky flag, set on the first violation
//   fault_code cause of the first violation
//   fault_dir  direction of the first violation
//   viol_count saturating count of cycles containing any violation
//   rotations  wrapping count of north red->green entries
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module traffic_light_monitor #(
    parameter int MIN_GREEN  = 3,
    parameter int MIN_YELLOW = 2,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  n_lights,
    input  logic [1:0]  s_lights,
    input  logic [1:0]  e_lights,
    input  logic [1:0]  w_lights,
    input  logic        clr_fault,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [1:0]  fault_dir,
    output logic [7:0]  viol_count,
    output logic [15:0] rotations
);

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] GREEN  = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;
    localparam logic [1:0] BAD    = 2'b11;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_S = 2'd1;
    localparam logic [1:0] DIR_E = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_ILLEGAL  = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_TRANS    = 3'd3;
    localparam logic [2:0] CODE_SHORT_G  = 3'd4;
    localparam logic [2:0] CODE_SHORT_Y  = 3'd5;
    localparam logic [2:0] CODE_ORDER    = 3'd6;

    localparam logic [CNT_W-1:0] DWELL_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_GREEN_C = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_YEL_C   = CNT_W'(MIN_YELLOW);

    // Element 0 of each packed array is north, matching the fault_dir encoding.
    logic [3:0][1:0]       cur;
    logic [3:0][1:0]       prev_q;
    logic [3:0][CNT_W-1:0] dwell_q;

    logic [3:0] illegal;
    logic [3:0] non_red;
    logic [3:0] bad_trans;
    logic [3:0] short_green;
    logic [3:0] short_yellow;
    logic [3:0] green_entry;
    logic [3:0] order_bad;
    logic       conflict;

    logic       viol_hit;
    logic [2:0] viol_code;
    logic [1:0] viol_dir;

    assign cur = {w_lights, e_lights, s_lights, n_lights};

    function automatic logic [1:0] lowest_dir(input logic [3:0] v);
        if (v[0])      return DIR_N;
        else if (v[1]) return DIR_S;
        else if (v[2]) return DIR_E;
        else           return DIR_W;
    endfunction

    // Per-direction checks of the current sample against prev and dwell.
    always_comb begin
        illegal      = '0;
        non_red      = '0;
        bad_trans    = '0;
        short_green  = '0;
        short_yellow = '0;
        green_entry  = '0;
        for (int i = 0; i < 4; i++) begin
            illegal[i]      = (cur[i] == BAD);
            non_red[i]      = (cur[i] != RED);
            bad_trans[i]    = ((prev_q[i] == RED)    && (cur[i] == YELLOW)) ||
                              ((prev_q[i] == GREEN)  && (cur[i] == RED))    ||
                              ((prev_q[i] == YELLOW) && (cur[i] == GREEN));
            short_green[i]  = (prev_q[i] == GREEN)  && (cur[i] == YELLOW) &&
                              (dwell_q[i] < MIN_GREEN_C);
            short_yellow[i] = (prev_q[i] == YELLOW) && (cur[i] == RED) &&
                              (dwell_q[i] < MIN_YEL_C);
            green_entry[i]  = (prev_q[i] == RED) && (cur[i] == GREEN);
        end
    end

    // More than one bit set: clearing the lowest set bit leaves something.
    assign conflict = ((non_red & (non_red - 4'd1)) != 4'd0);

`ifdef ORDER_CHECK_EN
    logic [1:0] last_green_q;

    function automatic logic [1:0] next_green(input logic [1:0] d);
        case (d)
            DIR_N:   return DIR_E;
            DIR_E:   return DIR_S;
            DIR_S:   return DIR_W;
            default: return DIR_N;
        endcase
    endfunction

    // A green entry is out of order unless it is the successor of the last one.
    always_comb begin
        order_bad = '0;
        for (int i = 0; i < 4; i++) begin
            order_bad[i] = green_entry[i] && (2'(i) != next_green(last_green_q));
        end
    end

    // Reset to W so that N is the expected first entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_green_q <= DIR_W;
        end else if (|green_entry) begin
            last_green_q <= lowest_dir(green_entry);
        end
    end
`else
    assign order_bad = '0;
`endif

    // Priority select: lowest code first, then lowest direction within it.
    always_comb begin
        viol_hit  = 1'b1;
        viol_code = CODE_NONE;
        viol_dir  = DIR_N;
        if (|illegal) begin
            viol_code = CODE_ILLEGAL;
            viol_dir  = lowest_dir(illegal);
        end else if (conflict) begin
            viol_code = CODE_CONFLICT;
            viol_dir  = lowest_dir(non_red);
        end else if (|bad_trans) begin
            viol_code = CODE_TRANS;
            viol_dir  = lowest_dir(bad_trans);
        end else if (|short_green) begin
            viol_code = CODE_SHORT_G;
            viol_dir  = lowest_dir(short_green);
        end else if (|short_yellow) begin
            viol_code = CODE_SHORT_Y;
            viol_dir  = lowest_dir(short_yellow);
        end else if (|order_bad) begin
            viol_code = CODE_ORDER;
            viol_dir  = lowest_dir(order_bad);
        end else begin
            viol_hit  = 1'b0;
        end
    end

    // History registers; illegal codes are tracked like any other code.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= {4{RED}};
            dwell_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                prev_q[i] <= cur[i];
                if (cur[i] != prev_q[i]) begin
                    dwell_q[i] <= CNT_W'(1);
                end else if (dwell_q[i] != DWELL_MAX) begin
                    dwell_q[i] <= dwell_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // North entry counter is independent of fault state and of clr_fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            rotations <= '0;
        end else if (green_entry[0]) begin
            rotations <= rotations + 16'd1;
        end
    end

    // Sticky fault capture; clr_fault wins over a same-cycle violation.
    always_ff @(posedge clk) begin
        if (rst || clr_fault) begin
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            fault_dir  <= DIR_N;
            viol_count <= '0;
        end else if (viol_hit) begin
            if (!fault) begin
                fault      <= 1'b1;
                fault_code <= viol_code;
                fault_dir  <= viol_dir;
            end
            if (viol_count != 8'hFF) begin
                viol_count <= viol_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive safety checker on the consuming side of the four-way intersection light buses. It samples the four 2-bit light codes driven by the intersection controller every clock and flags the first safety violation. Violations covered: illegal codes, conflicting non-red directions, illegal colour transitions and short green/yellow dwell. It sits beside the controller in the top level and in the benches, and its sticky fault output drives the lamp-board failsafe (all-red flash).

## Interface
- MIN_GREEN, 3, minimum number of consecutive sampled cycles a direction must stay green
- MIN_YELLOW, 2, minimum number of consecutive sampled cycles a direction must stay yellow
- CNT_W, 8, width of per-direction dwell counters; counters saturate at 2^CNT_W-1

Ports:
- clk  input  1  sole clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- n_lights  input  2  north light code
- s_lights  input  2  south light code
- e_lights  input  2  east light code
- w_lights  input  2  west light code
- clr_fault  input  1  synchronous clear of sticky fault state; rst has priority
- fault  output  1  sticky, set on first violation
- fault_code  output  3  cause of first violation
- fault_dir  output  2  direction of first violation: 0=N, 1=S, 2=E, 3=W
- viol_count  output  8  saturating count of cycles with any violation
- rotations  output  16  count of north red->green entries, wraps at 2^16

## Operation
- Light encoding: 2'b00 red, 2'b01 green, 2'b10 yellow, 2'b11 illegal.
- Per direction, the block holds a registered previous code (prev) and a dwell counter (dwell).
- Reset values:
  - prev = red for all directions.
  - dwell = 0.
  - fault = 0, fault_code = 0, fault_dir = 0.
  - viol_count = 0, rotations = 0.
- Legal transitions: red->green, green->yellow, yellow->red, and any code held unchanged.
- Each edge, the block checks the current inputs against prev and dwell:
  - Code 1 (illegal code): any input is 2'b11.
  - Code 2 (conflict): more than one direction is non-red. fault_dir reports the lowest-index non-red direction.
  - Code 3 (illegal transition): red->yellow, green->red or yellow->green.
  - Code 4 (short green): green->yellow with dwell < MIN_GREEN.
  - Code 5 (short yellow): yellow->red with dwell < MIN_YELLOW.
  - Code 6 (order): see Configuration.
- Simultaneous violations in one cycle:
  - Lowest code number wins.
  - Within that code, lowest direction index wins.
- Dwell counter rules:
  - A code change sets dwell to 1.
  - An unchanged code increments dwell, saturating.
  - An illegal code still updates prev and dwell normally.
- Fault latching:
  - If fault = 0 and any violation exists, the block sets fault and latches fault_code and fault_dir.
  - Later violations do not overwrite fault_code or fault_dir.
- viol_count increments in every cycle containing at least one violation. It saturates at 255 and counts independently of fault.
- clr_fault:
  - Zeroes fault, fault_code, fault_dir and viol_count.
  - Leaves prev, dwell and rotations untouched.
  - A violation in the same cycle as clr_fault is dropped.
- rotations increments on every north red->green transition, legal or not.

## Timing
- Outputs are registered. A violation present on the inputs during cycle k is visible on fault and fault_code after edge k, i.e. one cycle latency.
- The first edge after rst deasserts compares against the reset prev (all red). Green on one direction in that cycle is therefore legal.
- rst asserted mid-operation returns all state to reset values at that edge. A violation sampled at the same edge is discarded.
- Dwell is measured in sampled edges. A green held for exactly MIN_GREEN edges, then yellow, is legal; MIN_GREEN-1 faults.

## Configuration
- ORDER_CHECK_EN defined: the order check is compiled in.
  - A 2-bit last-green register is reset to W, so N is expected first.
  - Each red->green entry must be the successor of last-green in the order N->E->S->W->N. Otherwise the block flags code 6 with fault_dir = entering direction.
  - The last-green register updates on every green entry.
- ORDER_CHECK_EN undefined: no order logic is built, and code 6 is never produced.

## Test plan
- Legal cycle: rst, then N green 3, yellow 2, red; repeat for E, S, W; twice round. Expect fault=0, viol_count=0, rotations=2.
- Conflict: N green, then E green in the same cycle as N still green. Expect fault=1, fault_code=2, fault_dir=0 one cycle later; viol_count increments each overlapping cycle.
- Short dwell: N green 2 cycles then yellow. Expect fault_code=4, fault_dir=0. Separately, yellow 1 cycle then red. Expect fault_code=5.
- Priority and stickiness: W=2'b11 and S green->red in the same cycle. Expect fault_code=1, fault_dir=3. A later conflict leaves the code at 1. Pulse clr_fault: fault=0, viol_count=0, rotations unchanged.
- Reset mid-fault: apply rst during an active violation. Expect all outputs 0 after that edge; first cycle after rst, N green, gives no fault.
- ORDER_CHECK_EN build: N cycle legal, then S green. Expect fault_code=6, fault_dir=1. Non-EN build on the same stimulus: fault=0.
